// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
// Build option FAST_MUL_EN (see muldiv_ctrl) selects a single-cycle multiplier.
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply (mode 0) or
// restoring divide (mode 1) on a {high, low} double-width accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                mode,
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   operand,
  output logic [2*DATA_W-1:0] acc_next
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   top;
  logic [DATA_W+1:0] diff;

  // Multiply keeps the multiplier in the low half and shifts the partial product in from the top.
  always_comb begin
    sum      = '0;
    top      = acc[2*DATA_W-1:DATA_W-1];
    diff     = '0;
    acc_next = acc;
    if (mode) begin
      diff = {1'b0, top} - {2'b00, operand};
      if (!diff[DATA_W+1]) begin
        acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end else begin
        acc_next = {top[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, acc[2*DATA_W-1:DATA_W]} +
            (acc[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
      acc_next = {sum, acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer owning the HI/LO write path.
// Define FAST_MUL_EN to compute multiplies in a single RUN cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic              we_hilo,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  state_e              state;
  state_e              state_next;
  logic [1:0]          op_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg_res;
  logic                neg_rem;
  logic                zero_flag;

  logic                sgn_op;
  logic                div_op;
  logic [DATA_W:0]     a_wide;
  logic [DATA_W:0]     b_wide;
  logic [DATA_W:0]     abs_a;
  logic [DATA_W:0]     abs_b;
  logic [2*DATA_W-1:0] step_next;
  logic [2*DATA_W-1:0] run_acc;
  logic                run_last;
  logic [2*DATA_W-1:0] prod_neg;
  logic [DATA_W-1:0]   quo_neg;
  logic [DATA_W-1:0]   rem_neg;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  assign sgn_op = is_signed_op(op_r);
  assign div_op = is_div_op(op_r);

  // Widen by one bit so the magnitude of the most-negative value is exact.
  assign a_wide = {sgn_op & a_r[DATA_W-1], a_r};
  assign b_wide = {sgn_op & b_r[DATA_W-1], b_r};
  assign abs_a  = a_wide[DATA_W] ? (~a_wide + {{DATA_W{1'b0}}, 1'b1}) : a_wide;
  assign abs_b  = b_wide[DATA_W] ? (~b_wide + {{DATA_W{1'b0}}, 1'b1}) : b_wide;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .mode     (div_op),
    .acc      (acc),
    .operand  (b_r),
    .acc_next (step_next)
  );

`ifdef FAST_MUL_EN
  assign run_acc  = div_op ? step_next
                           : ({{DATA_W{1'b0}}, acc[DATA_W-1:0]} * {{DATA_W{1'b0}}, b_r});
  assign run_last = !div_op || (cnt == CNT_W'(DATA_W - 1));
`else
  assign run_acc  = step_next;
  assign run_last = (cnt == CNT_W'(DATA_W - 1));
`endif

  assign prod_neg = {(2*DATA_W){1'b0}} - acc;
  assign quo_neg  = {DATA_W{1'b0}} - acc[DATA_W-1:0];
  assign rem_neg  = {DATA_W{1'b0}} - acc[2*DATA_W-1:DATA_W];

  // Sign fix-up: remainder follows the dividend so division truncates toward zero.
  always_comb begin
    fix_hi = acc[2*DATA_W-1:DATA_W];
    fix_lo = acc[DATA_W-1:0];
    if (div_op) begin
      if (neg_res) fix_lo = quo_neg;
      else         fix_lo = acc[DATA_W-1:0];
      if (neg_rem) fix_hi = rem_neg;
      else         fix_hi = acc[2*DATA_W-1:DATA_W];
    end else if (neg_res) begin
      fix_hi = prod_neg[2*DATA_W-1:DATA_W];
      fix_lo = prod_neg[DATA_W-1:0];
    end else begin
      fix_hi = acc[2*DATA_W-1:DATA_W];
      fix_lo = acc[DATA_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a flush in DONE is ignored because that op is older than the flush.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start && !flush) state_next = ST_PREP;
        else                 state_next = ST_IDLE;
      end
      ST_PREP: begin
        if (flush)                      state_next = ST_IDLE;
        else if (div_op && b_r == '0)   state_next = ST_DONE;
        else                            state_next = ST_RUN;
      end
      ST_RUN: begin
        if (flush)         state_next = ST_IDLE;
        else if (run_last) state_next = ST_FIX;
        else               state_next = ST_RUN;
      end
      ST_FIX: begin
        if (flush) state_next = ST_IDLE;
        else       state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    we_hilo     = (state == ST_DONE) && !zero_flag;
    div_by_zero = (state == ST_DONE) && zero_flag;
    case (state)
      ST_IDLE:                 stall_req = start && !flush;
      ST_PREP, ST_RUN, ST_FIX: stall_req = 1'b1;
      default:                 stall_req = 1'b0;
    endcase
  end

  // Operand capture, iteration and HI/LO commit (HI/LO load on the FIX->DONE edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= 2'b00;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      zero_flag <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_r <= op;
            a_r  <= src_a;
            b_r  <= src_b;
          end
        end
        ST_PREP: begin
          b_r       <= abs_b[DATA_W-1:0];
          acc       <= {{DATA_W{1'b0}}, abs_a[DATA_W-1:0]};
          cnt       <= '0;
          neg_res   <= sgn_op & (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
          neg_rem   <= sgn_op & a_r[DATA_W-1];
          zero_flag <= div_op && (b_r == '0);
        end
        ST_RUN: begin
          acc <= run_acc;
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_FIX: begin
          if (!flush) begin
            hi_out <= fix_hi;
            lo_out <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected commits, a
// negedge monitor pops and compares them when done is seen.
module tb_muldiv_ctrl;

`ifdef FAST_MUL_EN
  localparam int LAT_MUL = 4;
`else
  localparam int LAT_MUL = 35;
`endif
  localparam int LAT_DIV = 35;
  localparam int LAT_Z   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic        flush = 1'b0;
  logic        busy, stall_req, done, we_hilo, div_by_zero;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          zero;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          req_id = 0;
  int          seen_id = 0;
  logic [31:0] want_hi = 32'h0;
  logic [31:0] want_lo = 32'h0;
  bit          stall_en = 1'b0;
  int          stall_t0 = 0;
  int          stall_lat = 0;
  int          t;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .stall_req(stall_req), .done(done),
    .we_hilo(we_hilo), .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_id != seen_id) begin
        seen_id = req_id;
        total += 1;
        if (busy !== 1'b0 || stall_req !== 1'b0 || done !== 1'b0 ||
            we_hilo !== 1'b0 || div_by_zero !== 1'b0) begin
          bad += 1;
          $display("FAIL idle_ctrl: busy=%b stall=%b done=%b we=%b dbz=%b required all 0",
                   busy, stall_req, done, we_hilo, div_by_zero);
        end
        total += 1;
        if (hi_out !== want_hi || lo_out !== want_lo) begin
          bad += 1;
          $display("FAIL idle_hilo: got %h/%h required %h/%h", hi_out, lo_out, want_hi, want_lo);
        end
      end
      if (stall_en && cyc >= stall_t0 && cyc <= stall_t0 + stall_lat) begin
        total += 1;
        if (stall_req !== (cyc < stall_t0 + stall_lat)) begin
          bad += 1;
          $display("FAIL stall_req: cycle t+%0d got %b required %b", cyc - stall_t0,
                   stall_req, (cyc < stall_t0 + stall_lat));
        end
      end
      if (done === 1'b1) begin
        total += 1;
        if (q.size() == 0) begin
          bad += 1;
          $display("FAIL unexpected_done: cycle %0d got done=1 required done=0", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc != e.cyc) begin
            bad += 1;
            $display("FAIL done_cycle: got %0d required %0d", cyc, e.cyc);
          end
          total += 1;
          if (hi_out !== e.hi || lo_out !== e.lo) begin
            bad += 1;
            $display("FAIL result: got hi=%h lo=%h required hi=%h lo=%h", hi_out, lo_out, e.hi, e.lo);
          end
          total += 1;
          if (we_hilo !== !e.zero || div_by_zero !== e.zero) begin
            bad += 1;
            $display("FAIL flags: got we=%b dbz=%b required we=%b dbz=%b",
                     we_hilo, div_by_zero, !e.zero, e.zero);
          end
        end
      end else if (q.size() != 0 && cyc > q[0].cyc + 2) begin
        total += 1;
        bad += 1;
        $display("FAIL done_timeout: no done by cycle %0d, required at %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // Called in the phase just after a rising edge; start is held for one cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit z,
                       input int lat, output int t0);
    exp_t e;
    t0     = cyc;
    e.cyc  = cyc + lat;
    e.hi   = eh;
    e.lo   = el;
    e.zero = z;
    q.push_back(e);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    step(2);
  endtask

  task automatic idle_check(input logic [31:0] h, input logic [31:0] l);
    want_hi = h; want_lo = l;
    req_id += 1;
    step(1);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    idle_check(32'h0, 32'h0);

    // signed multiply with stall_req profile
    stall_t0 = cyc; stall_lat = LAT_MUL; stall_en = 1'b1;
    issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT_MUL, t);
    drain();
    stall_en = 1'b0;

    issue(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, LAT_MUL, t);
    drain();
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_DIV, t);
    drain();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT_DIV, t);
    drain();

    // load hi/lo = 0x1234/0x5678, then divide by zero leaves them intact
    issue(2'b11, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 1'b0, LAT_DIV, t);
    drain();
    issue(2'b11, 32'h80000000, 32'h00000000, 32'h00001234, 32'h00005678, 1'b1, LAT_Z, t);
    drain();
    idle_check(32'h00001234, 32'h00005678);

    // flush on the 10th RUN cycle; nothing may commit
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_DIV, t);
    void'(q.pop_back());
    goto_cyc(t + 11);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    idle_check(32'h00001234, 32'h00005678);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_DIV, t);
    drain();

    // start during RUN is ignored; flush in the DONE cycle still commits
    issue(2'b11, 32'd50, 32'd6, 32'd2, 32'd8, 1'b0, LAT_DIV, t);
    goto_cyc(t + 10);
    op = 2'b01; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
    step(1);
    start = 1'b0;
    goto_cyc(t + LAT_DIV);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    drain();
    idle_check(32'd2, 32'd8);

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO write path.
- Replaces the single-cycle combinational mul/div in the execute stage.
- Accepts one op from EX, holds the pipeline via stall_req while an iterative shift-add / restoring-division datapath runs, then commits a 64-bit result to HI/LO.
- Supports pipeline flush (cancel) and reports divide-by-zero.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- src_a  in  DATA_W  multiplicand / dividend
- src_b  in  DATA_W  multiplier / divisor
- flush  in  1  cancel the in-flight op
- busy  out  1  state != IDLE
- stall_req  out  1  pipeline hold request
- done  out  1  one-cycle pulse when the op completes
- we_hilo  out  1  HI/LO write enable (one cycle)
- div_by_zero  out  1  one-cycle pulse with done for div/divu with src_b == 0
- hi_out  out  DATA_W  result high word / remainder
- lo_out  out  DATA_W  result low word / quotient

Behaviour:
- States: IDLE, PREP, RUN, FIX, DONE.
- Reset: state IDLE; counter 0; hi_out/lo_out 0; done, we_hilo, div_by_zero, busy, stall_req all 0. Reset mid-operation aborts with no write.
- IDLE:
  - start && !flush: latch op, src_a, src_b; go to PREP.
  - flush has priority over start: start is dropped.
- PREP:
  - Form absolute values for signed ops (two's complement negate when MSB set); record result sign and dividend sign.
  - div/divu with src_b == 0: go to DONE with zero flag set.
  - Otherwise: counter = 0; go to RUN.
- RUN: one iteration per cycle.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring step on a {remainder, quotient} register.
  - After DATA_W iterations (counter == DATA_W-1), go to FIX.
- FIX (signed ops only; unsigned ops pass through unchanged):
  - mult: negate the 64-bit product when the operand signs differ.
  - div: negate the quotient when the signs differ; the remainder takes the dividend's sign (truncation toward zero).
- DONE (one cycle):
  - done = 1.
  - Normal result: we_hilo = 1; hi_out/lo_out hold the new result from this cycle on.
  - Zero-divisor: div_by_zero = 1, we_hilo = 0, hi_out/lo_out unchanged.
  - Next state IDLE.
- Latency, start sampled in cycle t:
  - done in cycle t+DATA_W+3 (t+35 for DATA_W = 32).
  - Zero divisor: done in t+2.
- Outputs:
  - hi_out/lo_out are registered and hold the last committed result indefinitely.
  - stall_req = (state==IDLE && start && !flush) || (state in PREP, RUN, FIX). It deasserts in the DONE cycle so the stalled instruction advances with the result.
- start while busy: ignored; the issuing logic is held by stall_req.
- Flush:
  - In PREP, RUN or FIX: go to IDLE next cycle; no done, no write; hi_out/lo_out unchanged.
  - In the DONE cycle: ignored; the op is older than the flush and commits.
- Arithmetic:
  - Most-negative by -1: lo = 0x80000000, hi = 0 (natural wrap, no trap).
  - Operands are internally widened to DATA_W+1 bits so negation of 0x80000000 is exact.

Optional Feature:
- FAST_MUL_EN defined: mult/multu use a single-cycle DATA_W x DATA_W multiplier in RUN. RUN lasts exactly 1 cycle, so multiply done is in t+4; divide is unchanged.
- FAST_MUL_EN undefined: multiply uses the DATA_W-cycle shift-add path, with done in t+DATA_W+3.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum;
  - DATA_W default.
- One sub-module, muldiv_step: the combinational single-iteration datapath.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator.
  - muldiv_ctrl owns the state machine, counter, sign fix-up and HI/LO registers.

Test Plan:
- mult src_a=0xFFFFFFFF, src_b=0x00000002, start at t -> done/we_hilo at t+35; hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall_req high t..t+34, low at t+35.
- multu src_a=0xFFFFFFFF, src_b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; with FAST_MUL_EN, done at t+4.
- div src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu src_a=0x80000000, src_b=0 with prior hi/lo = 0x1234/0x5678 -> done and div_by_zero at t+2; we_hilo=0; hi/lo remain 0x1234/0x5678.
- divu 100/7 started, flush asserted at the 10th RUN cycle -> IDLE next cycle; no done; hi/lo unchanged. A new start the following cycle completes normally: lo=14, hi=2.
- start pulsed again during RUN with different operands -> ignored; original result committed; flush asserted in the DONE cycle -> write still occurs.
